voq_dequeue_sched: RTL
======================

// Module: voq_dequeue_sched
// PURPOSE
//  Read side of the input-VOQ packet counters. Takes the per-destination empty flags
//  (cnt_eq_zero) and picks a non-empty, ready queue round-robin. Requests the head packet
//  from shared memory and streams it to the egress side. Returns the decrement
//  (minus_sel/cnt_minus) to the packet counters when the packet's last beat is accepted.
//  One instance per voq_in_module, next to the packet counters.
// PARAMETERS
//  PORT_NUB     `PORT_NUB_TOTAL          number of destination queues
//  WIDTH_SEL    $clog2(`PORT_NUB_TOTAL)  queue index width
//  WIDTH_DATA   32                       data beat width
//  TIMEOUT_CYC  255                      starvation limit (only with VOQ_DEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst_n        in   1            asynchronous reset, active low
//  cnt_eq_zero  in   PORT_NUB     1 = queue i holds no packet
//  port_ready   in   PORT_NUB     1 = egress i can take a new packet (sampled in IDLE only)
//  rd_req       out  1            one-cycle pulse: fetch head packet of rd_port
//  rd_port      out  WIDTH_SEL    queue being read; stable from GRANT to SETTLE
//  mem_valid    in   1            memory beat valid
//  mem_data     in   WIDTH_DATA   memory beat data
//  mem_last     in   1            last beat of packet
//  mem_ready    out  1            beat accepted when mem_valid & mem_ready
//  out_valid    out  1            egress beat valid
//  out_data     out  WIDTH_DATA   egress beat data
//  out_last     out  1            egress last beat
//  out_port     out  WIDTH_SEL    destination of current beat
//  out_ready    in   1            egress accepts when out_valid & out_ready
//  minus_sel    out  WIDTH_SEL    queue to decrement
//  cnt_minus    out  1            one-cycle decrement strobe
//  busy         out  1            state != IDLE
//  timeout_err  out  1            present only with VOQ_DEQ_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state=IDLE, RR pointer=0. All outputs 0, including rd_req, rd_port, out_*,
//   minus_sel, cnt_minus, busy and timeout_err.
//  Reset is async and may hit mid-packet: the packet is abandoned with no cnt_minus.
//   The counters are reset by the same rst_n.
//  FSM IDLE -> GRANT -> XFER -> SETTLE -> IDLE.
//  IDLE: req = ~cnt_eq_zero & port_ready.
//   If req != 0: pick the first set bit at or after the RR pointer (wrap at PORT_NUB-1 -> 0),
//   latch cur_port, then go to GRANT. Otherwise stay in IDLE.
//  GRANT: rd_req=1 and rd_port=cur_port for exactly one cycle, then go to XFER.
//  XFER: mem_ready = ~out_valid | out_ready (one-entry output register, no bubble at full rate).
//   Each accepted beat loads out_data, out_last and out_port=cur_port, and sets out_valid.
//   out_valid clears when accepted with no new beat loaded.
//   When a beat with mem_last is accepted: cnt_minus=1 and minus_sel=cur_port in that same
//   cycle, RR pointer <= cur_port+1 (wrapping), then go to SETTLE.
//  SETTLE: one cycle, mem_ready=0; the counter's cnt_eq_zero update becomes visible.
//   The final out beat may still be pending in SETTLE or IDLE.
//   The next packet's first beat cannot load until that out beat drains.
//  cnt_minus is never asserted outside the last-beat/timeout cycle, and at most once per grant.
//  A simultaneous counter add on the same queue is the counter's concern; this block needs no
//   special handling.
//  port_ready dropping after the grant is ignored; the packet completes.
//  A 1-beat packet (mem_last on the first beat) is legal.
// CONFIGURATION
//  `VOQ_DEQ_TIMEOUT_EN defined:
//   In XFER, a counter increments on each cycle with mem_ready & ~mem_valid.
//   It clears on every accepted beat and on entry to XFER.
//   At TIMEOUT_CYC: one-cycle pulse on timeout_err, cnt_minus with minus_sel=cur_port
//   (packet dropped), RR advance, go to SETTLE. No forced out_last.
//  Not defined: no timeout_err port and no counter; XFER waits indefinitely.
// STRUCTURE
//  PORT_NUB_TOTAL comes from generate_parameter.vh, shared with the packet counters.
//  State encoding localparams (IDLE/GRANT/XFER/SETTLE) and the timeout width go in a
//   shared voq_pkg.vh.
//  Sub-module rr_arbiter (req, pointer -> one-hot grant + index), reusable by the output
//   scheduler.
// TESTING (PORT_NUB=4, WIDTH_DATA=32)
//  1 cnt_eq_zero=4'b1011, port_ready=4'hF, 3-beat packet A0/A1/A2
//    -> rd_req with rd_port=2 one cycle after leaving IDLE.
//    -> out_port=2 on all beats, out_last on A2.
//    -> cnt_minus=1 and minus_sel=2 in the cycle A2 is accepted.
//  2 Queues 0,1,3 non-empty, 1-beat packets, out_ready=1 -> grant order 0,1,3,0,1,3.
//  3 out_ready low for 5 cycles mid-packet
//    -> mem_ready=0 while out_valid & ~out_ready.
//    -> beats arrive in order, none lost or duplicated.
//  4 cnt_eq_zero=4'b1100, port_ready=4'b1110 -> queue 0 never granted, queue 1 granted.
//  5 rst_n low during XFER beat 2
//    -> all outputs 0 immediately, no cnt_minus.
//    -> after release, IDLE and RR pointer 0.
//  6 Macro on, TIMEOUT_CYC=8, mem_valid held low 8 cycles in XFER
//    -> timeout_err pulse and cnt_minus (minus_sel=cur_port) the same cycle.
//    -> IDLE two cycles later.

Source files
------------

// File: rtl/voq_dequeue_sched_pkg.sv
// Shared definitions for the VOQ dequeue scheduler: queue count, FSM state
// encoding, timeout counter width and a round-robin pointer helper.
// Optional feature macro used by the design: VOQ_DEQ_TIMEOUT_EN.
package voq_dequeue_sched_pkg;

   // Number of destination queues, shared with the packet counters
   localparam int PORT_NUB_TOTAL = 4;

   // Stall counter width; must be able to hold TIMEOUT_CYC-1
   localparam int TIMEOUT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_XFER   = 2'd2,
      ST_SETTLE = 2'd3
   } deq_state_t;

   // Index following idx, wrapping from n-1 back to 0
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/voq_dequeue_sched_if.sv
// Memory-read and egress beat channels of the VOQ dequeue scheduler.
// master = scheduler side, slave = memory/egress side.
interface voq_dequeue_sched_if
   import voq_dequeue_sched_pkg::*;
#(
   parameter int WIDTH_SEL  = $clog2(PORT_NUB_TOTAL),
   parameter int WIDTH_DATA = 32
);

   logic                  mem_valid;
   logic [WIDTH_DATA-1:0] mem_data;
   logic                  mem_last;
   logic                  mem_ready;

   logic                  out_valid;
   logic [WIDTH_DATA-1:0] out_data;
   logic                  out_last;
   logic [WIDTH_SEL-1:0]  out_port;
   logic                  out_ready;

   modport master (
      input  mem_valid, mem_data, mem_last, out_ready,
      output mem_ready, out_valid, out_data, out_last, out_port
   );

   modport slave (
      output mem_valid, mem_data, mem_last, out_ready,
      input  mem_ready, out_valid, out_data, out_last, out_port
   );

endinterface

// File: rtl/voq_dequeue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or
// after ptr, wrapping from N-1 to 0. Returns a one-hot grant and its index.
// Kept generic so the output scheduler can reuse it.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx
);

   logic [W:0]   pos;
   logic         found;

   // Walk the request vector starting at ptr and take the first hit
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         pos = {1'b0, ptr} + (W+1)'(i);
         if (pos >= (W+1)'(N)) begin
            pos = pos - (W+1)'(N);
         end
         if (!found && req[pos[W-1:0]]) begin
            found              = 1'b1;
            grant[pos[W-1:0]]  = 1'b1;
            idx                = pos[W-1:0];
         end
      end
   end

endmodule

// File: rtl/voq_dequeue_sched.sv
// VOQ dequeue scheduler: round-robin selects a non-empty, ready queue,
// requests its head packet from shared memory, streams the beats to egress
// through a one-entry output register and returns a counter decrement when
// the last beat is accepted.
// Optional macro VOQ_DEQ_TIMEOUT_EN adds a starvation timeout that drops the
// packet and raises timeout_err.
module voq_dequeue_sched
   import voq_dequeue_sched_pkg::*;
#(
   parameter int PORT_NUB    = PORT_NUB_TOTAL,
   parameter int WIDTH_SEL   = $clog2(PORT_NUB_TOTAL),
   parameter int WIDTH_DATA  = 32
`ifdef VOQ_DEQ_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PORT_NUB-1:0]  cnt_eq_zero,
   input  logic [PORT_NUB-1:0]  port_ready,
   output logic                 rd_req,
   output logic [WIDTH_SEL-1:0] rd_port,
   voq_dequeue_sched_if.master  bus,
   output logic [WIDTH_SEL-1:0] minus_sel,
   output logic                 cnt_minus,
`ifdef VOQ_DEQ_TIMEOUT_EN
   output logic                 timeout_err,
`endif
   output logic                 busy
);

   deq_state_t            state, state_nx;
   logic [WIDTH_SEL-1:0]  cur_port, rr_ptr, arb_idx;
   logic [PORT_NUB-1:0]   req, arb_grant;
   logic                  any_req, mem_ready_c, beat_acc, done, timeout_hit;

   logic                  out_valid_q, out_last_q;
   logic [WIDTH_DATA-1:0] out_data_q;
   logic [WIDTH_SEL-1:0]  out_port_q;

   assign req     = ~cnt_eq_zero & port_ready;
   assign any_req = |arb_grant;

   rr_arbiter #(.N(PORT_NUB), .W(WIDTH_SEL)) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   // A memory beat is taken only in XFER and only if the output slot frees up
   assign mem_ready_c = (state == ST_XFER) && (!out_valid_q || bus.out_ready);
   assign beat_acc    = bus.mem_valid && mem_ready_c;
   assign done        = (beat_acc && bus.mem_last) || timeout_hit;

`ifdef VOQ_DEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] stall_cnt;

   assign timeout_hit = mem_ready_c && !bus.mem_valid &&
                        (stall_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
   assign timeout_err = timeout_hit;

   // Count cycles the scheduler waits on memory; restart on each beat and per packet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state != ST_XFER || beat_acc) begin
         stall_cnt <= '0;
      end else if (mem_ready_c && !bus.mem_valid) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: IDLE -> GRANT -> XFER -> SETTLE -> IDLE
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (any_req) state_nx = ST_GRANT;
         ST_GRANT:  state_nx = ST_XFER;
         ST_XFER:   if (done) state_nx = ST_SETTLE;
         ST_SETTLE: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Latch the granted queue and advance the round-robin pointer past it on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_port <= '0;
         rr_ptr   <= '0;
      end else begin
         if (state == ST_IDLE && any_req) begin
            cur_port <= arb_idx;
         end
         if (done) begin
            rr_ptr <= WIDTH_SEL'(rr_next(int'(cur_port), PORT_NUB));
         end
      end
   end

   // One-entry egress register; may still hold the last beat after the packet ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_port_q  <= '0;
      end else if (beat_acc) begin
         out_valid_q <= 1'b1;
         out_data_q  <= bus.mem_data;
         out_last_q  <= bus.mem_last;
         out_port_q  <= cur_port;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.mem_ready = mem_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_port  = out_port_q;

   assign rd_req    = (state == ST_GRANT);
   assign rd_port   = cur_port;
   assign cnt_minus = done;
   assign minus_sel = done ? cur_port : '0;
   assign busy      = (state != ST_IDLE);

endmodule
